tcdm_rsp_rob: RTL

TCDM_RSP_ROB -- requirements
Module: tcdm_rsp_rob

---
 rtl/tcdm_rsp_rob.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tcdm_rsp_rob.sv
// tcdm_rsp_rob: reorder buffer that hands out transaction IDs toward
// tcdm_shim, collects the shim's out-of-order responses into per-ID entries,
// and returns them to the core strictly in allocation order.

module tcdm_rsp_rob #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumEntries  = 8,
  parameter int unsigned MetaIdWidth = (NumEntries > 32'd1) ? $clog2(NumEntries) : 32'd1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   core_qvalid_i,
  output logic                   core_qready_o,
  output logic                   shim_qvalid_o,
  input  logic                   shim_qready_i,
  output logic [MetaIdWidth-1:0] shim_qid_o,
  input  logic                   shim_pvalid_i,
  output logic                   shim_pready_o,
  input  logic [MetaIdWidth-1:0] shim_pid_i,
  input  logic [DataWidth-1:0]   shim_pdata_i,
  input  logic                   shim_pwrite_i,
  input  logic                   shim_perror_i,
  output logic                   core_pvalid_o,
  input  logic                   core_pready_i,
  output logic [DataWidth-1:0]   core_pdata_o,
  output logic                   core_pwrite_o,
  output logic                   core_perror_o,
  output logic [MetaIdWidth:0]   usage_o,
  output logic                   empty_o
);

  // Depth must be a power of two so the pointers wrap cleanly.
  if ((NumEntries < 32'd2) || ((NumEntries & (NumEntries - 32'd1)) != 32'd0)) begin : g_bad_entries
    $fatal(1, "tcdm_rsp_rob: NumEntries must be a power of two and at least 2");
  end

  localparam logic [MetaIdWidth-1:0] LastIdx   = MetaIdWidth'(NumEntries - 32'd1);
  localparam logic [MetaIdWidth-1:0] IdxOne    = MetaIdWidth'(1'b1);
  localparam logic [MetaIdWidth:0]   FullCount = (MetaIdWidth + 1)'(NumEntries);
  localparam logic [MetaIdWidth:0]   CountOne  = (MetaIdWidth + 1)'(1'b1);
  localparam logic [MetaIdWidth:0]   CountZero = (MetaIdWidth + 1)'(1'b0);

  logic [MetaIdWidth-1:0] head_r;
  logic [MetaIdWidth-1:0] tail_r;
  logic [MetaIdWidth:0]   count_r;
  logic [NumEntries-1:0]  stored_r;
  logic [DataWidth-1:0]   data_r  [NumEntries];
  logic                   write_r [NumEntries];
  logic                   error_r [NumEntries];

  logic                   full_s;
  logic                   alloc_s;
  logic                   release_s;
  logic [MetaIdWidth-1:0] offset_s;
  logic                   allocated_s;
  logic                   rsp_ok_s;

  // Full is judged on the registered count only, so a same-cycle release
  // never opens the request path combinationally.
  assign full_s        = (count_r == FullCount);
  assign shim_qvalid_o = core_qvalid_i & ~full_s;
  assign core_qready_o = shim_qready_i & ~full_s;
  assign shim_qid_o    = tail_r;
  assign alloc_s       = shim_qvalid_o & shim_qready_i;

  // Every accepted response already owns a reserved entry.
  assign shim_pready_o = 1'b1;

  // An ID is live when its distance from head is below the count.
  assign offset_s    = shim_pid_i - head_r;
  assign allocated_s = ({1'b0, offset_s} < count_r);
  assign rsp_ok_s    = shim_pvalid_i & allocated_s & ~stored_r[shim_pid_i];

  // In-order side reads straight from the head entry's registers.
  assign core_pvalid_o = stored_r[head_r];
  assign core_pdata_o  = data_r[head_r];
  assign core_pwrite_o = write_r[head_r];
  assign core_perror_o = error_r[head_r];
  assign release_s     = core_pvalid_o & core_pready_i;

  assign usage_o = count_r;
  assign empty_o = (count_r == CountZero);

  // Head, tail and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (alloc_s) begin
        tail_r <= (tail_r == LastIdx) ? '0 : (tail_r + IdxOne);
      end
      if (release_s) begin
        head_r <= (head_r == LastIdx) ? '0 : (head_r + IdxOne);
      end
      case ({alloc_s, release_s})
        2'b10:   count_r <= count_r + CountOne;
        2'b01:   count_r <= count_r - CountOne;
        default: count_r <= count_r;
      endcase
    end
  end

  // Stored-response bits: cleared on allocate and on release, set when the
  // response lands. A freshly freed ID cannot be live, so the set never
  // collides with a clear of the same bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stored_r <= '0;
    end else begin
      if (alloc_s) begin
        stored_r[tail_r] <= 1'b0;
      end
      if (release_s) begin
        stored_r[head_r] <= 1'b0;
      end
      if (rsp_ok_s) begin
        stored_r[shim_pid_i] <= 1'b1;
      end
    end
  end

  // Response payload capture; visible to the core one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumEntries); i++) begin
        data_r[i]  <= '0;
        write_r[i] <= 1'b0;
        error_r[i] <= 1'b0;
      end
    end else if (rsp_ok_s) begin
      data_r[shim_pid_i]  <= shim_pdata_i;
      write_r[shim_pid_i] <= shim_pwrite_i;
      error_r[shim_pid_i] <= shim_perror_i;
    end
  end

  tcdm_rsp_rob_checker u_checker (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .shim_pvalid_i (shim_pvalid_i),
    .rsp_ok_i      (rsp_ok_s)
  );

endmodule

// tcdm_rsp_rob_checker: simulation-only protocol checks for the ROB.
module tcdm_rsp_rob_checker (
  input logic clk_i,
  input logic rst_i,
  input logic shim_pvalid_i,
  input logic rsp_ok_i
);

  // A response must target a live entry that has not been answered yet.
  a_rsp_target_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    !(shim_pvalid_i && !rsp_ok_i));

endmodule
